avalon_multi_ranger: RTL and testbench
======================================

AVALON_MULTI_RANGER -- requirements
Module: avalon_multi_ranger

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of ultrasonic channels (legal 1..8).
REQ-002 SHALL have parameter COUNT_W, default 22, echo-count width in bits.
REQ-003 SHALL have parameter TRIG_CYCLES, default 500, trigger pulse length in clocks.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2**21, maximum echo window in clocks.
REQ-005 SHALL have parameter HOLDOFF_CYCLES, default 3000000, settle gap between channel pings.
REQ-006 SHALL have parameter BASE_ADDR, default 16'h0900, register window base.
REQ-007 SHALL have ports: clk in 1 system clock; reset_l in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: io_select in 1 bus access strobe; write in 1 access is a write (0 = read); address in 16 byte address.
REQ-009 SHALL have ports: write_data in 32 write data; read_data out 32 registered read data.
REQ-010 SHALL have ports: echo in N_CH asynchronous sensor echoes; trigger out N_CH sensor triggers; irq out 1 scan-done interrupt.

Function
REQ-011 SHALL map CH[k] at BASE_ADDR+4k (read-only), CTRL at BASE_ADDR+16'h40 (bit0 enable, bit1 continuous, bit2 irq_en), STATUS at BASE_ADDR+16'h44 (bit0 scan_done, write-1-to-clear; bits[10:8] current channel, read-only).
REQ-012 SHALL format CH[k] as [31] valid, [30] timeout, [29:COUNT_W] zero, [COUNT_W-1:0] count.
REQ-013 SHALL update read_data on the clock after io_select=1, write=0 and an in-window address; unmapped in-window offsets return 0; otherwise read_data holds.
REQ-014 SHALL ignore accesses outside the window and writes to CH[k].
REQ-015 SHALL pass each echo bit through a two-flop synchroniser before any use.
REQ-016 SHALL run states IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF, operating on one channel at a time, channel 0 first.
REQ-017 IDLE->TRIG when enable=1; TRIG drives trigger[ch]=1 for exactly TRIG_CYCLES clocks, all other triggers 0.
REQ-018 WAIT_RISE->MEASURE on synced echo[ch] low-to-high; the timeout counter starts at TRIG exit and runs through WAIT_RISE and MEASURE.
REQ-019 MEASURE counts clocks while synced echo[ch]=1; on falling edge store count, valid=1, timeout=0 into CH[ch].
REQ-020 SHALL, when the timeout counter reaches TIMEOUT_CYCLES in WAIT_RISE or MEASURE, store count = saturated all-ones in COUNT_W bits, valid=1, timeout=1; echo stuck high therefore times out.
REQ-021 HOLDOFF lasts HOLDOFF_CYCLES, then advances ch; after ch=N_CH-1, set scan_done and wrap to 0: continuous=1 -> TRIG, else -> IDLE and clear enable.
REQ-022 SHALL clear CH[k].valid on a read of CH[k]; a result store in the same cycle wins (valid stays 1, read returns the pre-store value).
REQ-023 SHALL, when enable is written 0 mid-scan, abort to IDLE next clock with trigger all 0, store nothing, and reset ch to 0.
REQ-024 irq = scan_done AND irq_en, combinational from registers; a simultaneous W1C and a new scan_done set leaves scan_done=1.

Reset
REQ-025 SHALL, on reset_l low, asynchronously set state IDLE, ch 0, all counters 0, CTRL 0, scan_done 0, CH[k] 0, read_data 0, trigger 0, irq 0, synchronisers 0.
REQ-026 SHALL, on reset mid-TRIG, drop trigger without waiting for a clock edge.

Structure
REQ-027 SHALL place the state enum, the register offsets (CH, CTRL, STATUS), and the CTRL/STATUS bit positions in shared package ranger_pkg.
REQ-028 SHALL instantiate a sub-module echo_sync (one-bit two-flop synchroniser with async active-low reset) once per channel.
REQ-029 SHALL use a single shared timer and count register for all channels, not per-channel counters.

Verification (N_CH=2, TRIG_CYCLES=10, TIMEOUT_CYCLES=1000, HOLDOFF_CYCLES=50, COUNT_W=22)
REQ-030 Write CTRL=1; echo[0] high 200 clocks, echo[1] high 300 clocks -> trigger[0] is a 10-cycle pulse before trigger[1]; CH0=0x800000C8, CH1=0x8000012C; scan_done=1; enable reads 0.
REQ-031 Echo[1] never rises -> CH1 = 0xC03FFFFF after 1000 clocks; scan still completes.
REQ-032 Read CH0 twice after a scan -> first read returns valid=1, second returns valid=0 with the same count.
REQ-033 CTRL=0x7 -> irq rises at end of each scan; write STATUS=1 -> irq drops the next clock; scans repeat without a write.
REQ-034 Write CTRL=0 during MEASURE on ch1 -> trigger all 0 and state IDLE next clock; CH1 unchanged.
REQ-035 Pulse reset_l low during TRIG -> trigger drops immediately; all registers read 0 afterwards.

Source files
------------

// File: rtl/ranger_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranger: FSM states, register map
// offsets relative to the window base, and control/status bit positions.
package ranger_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StHoldoff
  } ranger_state_e;

  localparam logic [15:0] ChOffset     = 16'h0000;
  localparam logic [15:0] CtrlOffset   = 16'h0040;
  localparam logic [15:0] StatusOffset = 16'h0044;
  localparam logic [15:0] WinSize      = 16'h0080;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlContBit   = 1;
  localparam int unsigned CtrlIrqEnBit  = 2;

  localparam int unsigned StatusDoneBit = 0;
  localparam int unsigned StatusChLsb   = 8;

  localparam int unsigned ChValidBit   = 31;
  localparam int unsigned ChTimeoutBit = 30;

endpackage

// File: rtl/echo_sync.sv
// One-bit two-flop synchroniser for an asynchronous sensor echo line.
module echo_sync (
  input  logic clk,
  input  logic reset_l,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/avalon_multi_ranger.sv
// Round-robin ultrasonic ranger: pings one channel at a time, times its echo with a shared
// timer/counter, and exposes per-channel results plus control/status over a simple bus.
module avalon_multi_ranger
  import ranger_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned COUNT_W        = 22,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 2**21,
  parameter int unsigned HOLDOFF_CYCLES = 3000000,
  parameter logic [15:0] BASE_ADDR      = 16'h0900
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic            io_select,
  input  logic            write,
  input  logic [15:0]     address,
  input  logic [31:0]     write_data,
  output logic [31:0]     read_data,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] trigger,
  output logic            irq
);

  logic [N_CH-1:0] echo_s;

  for (genvar k = 0; k < N_CH; k++) begin : g_sync
    echo_sync u_echo_sync (
      .clk    (clk),
      .reset_l(reset_l),
      .d      (echo[k]),
      .q      (echo_s[k])
    );
  end

  ranger_state_e      state_q;
  logic [2:0]         ch_q;
  logic [31:0]        timer_q;
  logic [COUNT_W-1:0] count_q;
  logic [N_CH-1:0]    trigger_q;
  logic [N_CH-1:0]    echo_prev_q;
  logic [2:0]         ctrl_q;
  logic               scan_done_q;
  logic [31:0]        ch_data_q [N_CH];

  logic        unused_wdata;
  assign unused_wdata = ^write_data[31:3];

  // Bus decode
  logic [15:0] offset;
  logic        rd_en, wr_ctrl, wr_status, abort;
  logic [31:0] rd_val;

  always_comb begin
    offset    = address - BASE_ADDR;
    rd_en     = io_select && !write && (offset < WinSize);
    wr_ctrl   = io_select && write && (offset == CtrlOffset);
    wr_status = io_select && write && (offset == StatusOffset);
    abort     = wr_ctrl && !write_data[CtrlEnableBit] && (state_q != StIdle);

    rd_val = '0;
    if (offset == CtrlOffset) begin
      rd_val[2:0] = ctrl_q;
    end else if (offset == StatusOffset) begin
      rd_val[StatusDoneBit]        = scan_done_q;
      rd_val[StatusChLsb +: 3]     = ch_q;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (offset == ChOffset + 16'(4 * k)) rd_val = ch_data_q[k];
      end
    end
  end

  // Channel-scan datapath decisions shared by the FSM and the register file
  logic [7:0]      echo_pad, prev_pad;
  logic            echo_cur, echo_rise, last_ch, timed_out, hold_done, store, scan_end;
  logic [2:0]      next_ch;
  logic [N_CH-1:0] next_onehot;
  logic [31:0]     store_word;

  always_comb begin
    echo_pad    = 8'(echo_s);
    prev_pad    = 8'(echo_prev_q);
    echo_cur    = echo_pad[ch_q];
    echo_rise   = echo_cur && !prev_pad[ch_q];
    last_ch     = (ch_q == 3'(N_CH - 1));
    next_ch     = last_ch ? 3'd0 : ch_q + 3'd1;
    next_onehot = N_CH'(1) << next_ch;
    timed_out   = (timer_q == 32'(TIMEOUT_CYCLES - 1));
    hold_done   = (timer_q == 32'(HOLDOFF_CYCLES - 1));

    store      = 1'b0;
    store_word = '0;
    if (!abort) begin
      // A completed echo beats a timeout landing in the same cycle
      if (state_q == StMeasure && !echo_cur) begin
        store                      = 1'b1;
        store_word[COUNT_W-1:0]    = count_q;
      end else if ((state_q == StWaitRise || state_q == StMeasure) && timed_out) begin
        store                      = 1'b1;
        store_word[COUNT_W-1:0]    = '1;
        store_word[ChTimeoutBit]   = 1'b1;
      end
    end
    store_word[ChValidBit] = 1'b1;

    scan_end = !abort && (state_q == StHoldoff) && hold_done && last_ch;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= StIdle;
      ch_q        <= 3'd0;
      timer_q     <= '0;
      count_q     <= '0;
      trigger_q   <= '0;
      echo_prev_q <= '0;
    end else begin
      echo_prev_q <= echo_s;
      if (abort) begin
        state_q   <= StIdle;
        ch_q      <= 3'd0;
        timer_q   <= '0;
        count_q   <= '0;
        trigger_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (ctrl_q[CtrlEnableBit]) begin
              state_q   <= StTrig;
              ch_q      <= 3'd0;
              timer_q   <= '0;
              trigger_q <= N_CH'(1);
            end
          end
          StTrig: begin
            if (timer_q == 32'(TRIG_CYCLES - 1)) begin
              state_q   <= StWaitRise;
              timer_q   <= '0;
              trigger_q <= '0;
            end else begin
              timer_q <= timer_q + 32'd1;
            end
          end
          StWaitRise: begin
            timer_q <= timer_q + 32'd1;
            if (store) begin
              state_q <= StHoldoff;
              timer_q <= '0;
            end else if (echo_rise) begin
              state_q <= StMeasure;
              count_q <= COUNT_W'(1);
            end
          end
          StMeasure: begin
            timer_q <= timer_q + 32'd1;
            if (store) begin
              state_q <= StHoldoff;
              timer_q <= '0;
            end else begin
              count_q <= count_q + COUNT_W'(1);
            end
          end
          StHoldoff: begin
            if (hold_done) begin
              ch_q    <= next_ch;
              timer_q <= '0;
              if (!last_ch || ctrl_q[CtrlContBit]) begin
                state_q   <= StTrig;
                trigger_q <= next_onehot;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              timer_q <= timer_q + 32'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ctrl_q      <= '0;
      scan_done_q <= 1'b0;
      read_data   <= '0;
      for (int k = 0; k < N_CH; k++) ch_data_q[k] <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= write_data[2:0];
      end else if (scan_end && !ctrl_q[CtrlContBit]) begin
        ctrl_q[CtrlEnableBit] <= 1'b0;
      end

      if (scan_end) begin
        scan_done_q <= 1'b1;
      end else if (wr_status && write_data[StatusDoneBit]) begin
        scan_done_q <= 1'b0;
      end

      if (rd_en) read_data <= rd_val;

      // A result store outranks the read-side valid clear
      for (int k = 0; k < N_CH; k++) begin
        if (store && ch_q == 3'(k)) begin
          ch_data_q[k] <= store_word;
        end else if (rd_en && offset == ChOffset + 16'(4 * k)) begin
          ch_data_q[k][ChValidBit] <= 1'b0;
        end
      end
    end
  end

  assign trigger = trigger_q;
  assign irq     = scan_done_q && ctrl_q[CtrlIrqEnBit];

endmodule

// File: tb/tb_avalon_multi_ranger.sv
// Bench for avalon_multi_ranger: sensor responders answer each trigger with a configured echo,
// and expected channel words come from echo length alone.
module tb_avalon_multi_ranger;

  localparam logic [15:0] Base  = 16'h0900;
  localparam logic [15:0] CtrlA = Base + 16'h0040;
  localparam logic [15:0] StatA = Base + 16'h0044;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        io_select = 1'b0;
  logic        write = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        echo0 = 1'b0;
  logic        echo1 = 1'b0;
  logic [1:0]  echo;
  logic [1:0]  trigger;
  logic        irq;

  assign echo = {echo1, echo0};

  avalon_multi_ranger #(
    .N_CH          (2),
    .COUNT_W       (22),
    .TRIG_CYCLES   (10),
    .TIMEOUT_CYCLES(1000),
    .HOLDOFF_CYCLES(50),
    .BASE_ADDR     (16'h0900)
  ) dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .io_select (io_select),
    .write     (write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .echo      (echo),
    .trigger   (trigger),
    .irq       (irq)
  );

  initial forever #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  int          len [2] = '{0, 0};
  int          dly [2] = '{1, 1};
  logic [31:0] model_ch [2] = '{32'd0, 32'd0};
  int          pulse_ch [$];
  int          pulse_len [$];
  int          trig_run [2] = '{0, 0};
  int          overlap = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  // Trigger pulse monitor
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (trigger[k] === 1'b1) trig_run[k]++;
      else if (trig_run[k] != 0) begin
        pulse_ch.push_back(k);
        pulse_len.push_back(trig_run[k]);
        trig_run[k] = 0;
      end
    end
    if (trigger === 2'b11) overlap++;
  end

  // Sensor 0: after its trigger ends, wait dly clocks, then echo high for len clocks
  initial forever begin
    @(negedge clk);
    if (trigger[0] === 1'b1) begin
      while (trigger[0] === 1'b1) @(negedge clk);
      repeat (dly[0]) @(negedge clk);
      if (len[0] > 0) begin
        echo0 = 1'b1;
        repeat (len[0]) @(negedge clk);
        echo0 = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (trigger[1] === 1'b1) begin
      while (trigger[1] === 1'b1) @(negedge clk);
      repeat (dly[1]) @(negedge clk);
      if (len[1] > 0) begin
        echo1 = 1'b1;
        repeat (len[1]) @(negedge clk);
        echo1 = 1'b0;
      end
    end
  end

  // No echo, or one longer than the 1000-clock window, yields a saturated timeout word
  function automatic logic [31:0] expect_ch(input int l);
    if (l == 0 || l > 900) return 32'hC03F_FFFF;
    return 32'h8000_0000 | 32'(l);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    io_select = 1'b1; write = 1'b1; address = a; write_data = d;
    @(negedge clk);
    io_select = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    io_select = 1'b1; write = 1'b0; address = a;
    @(negedge clk);
    io_select = 1'b0;
    d = read_data;
  endtask

  task automatic read_ch(input int k, input string tag);
    logic [31:0] d;
    bus_read(Base + 16'(4 * k), d);
    check(tag, d, model_ch[k]);
    model_ch[k][31] = 1'b0;
  endtask

  task automatic poll_done(input string tag);
    logic [31:0] d = '0;
    int n = 0;
    while (d[0] !== 1'b1 && n < 3000) begin
      bus_read(StatA, d);
      n++;
    end
    check(tag, {31'd0, d[0]}, 32'd1);
  endtask

  task automatic wait_trig(input int k, input logic lvl, input string tag);
    int n = 0;
    while (trigger[k] !== lvl && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, trigger[k]}, {31'd0, lvl});
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (irq !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, irq}, 32'd1);
  endtask

  task automatic wait_echo_idle();
    int n = 0;
    while (echo !== 2'b00 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("echo_idle", {30'd0, echo}, 32'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_pulses(input string tag);
    check($sformatf("%s_pulse_count", tag), 32'(pulse_ch.size()), 32'd2);
    for (int i = 0; i < pulse_ch.size() && i < 2; i++) begin
      check($sformatf("%s_pulse%0d_ch", tag, i), 32'(pulse_ch[i]), 32'(i));
      check($sformatf("%s_pulse%0d_len", tag, i), 32'(pulse_len[i]), 32'd10);
    end
    check($sformatf("%s_overlap", tag), 32'(overlap), 32'd0);
    pulse_ch.delete();
    pulse_len.delete();
  endtask

  task automatic run_scan(input string tag);
    logic [31:0] d;
    bus_write(StatA, 32'd1);
    pulse_ch.delete();
    pulse_len.delete();
    bus_write(CtrlA, 32'd1);
    poll_done({tag, "_done"});
    check_pulses(tag);
    bus_read(StatA, d);
    check({tag, "_status"}, d, 32'h0000_0001);
    bus_read(CtrlA, d);
    check({tag, "_ctrl"}, d, 32'd0);
    for (int k = 0; k < 2; k++) model_ch[k] = expect_ch(len[k]);
    read_ch(0, {tag, "_ch0"});
    read_ch(1, {tag, "_ch1"});
    wait_echo_idle();
  endtask

  initial begin
    logic [31:0] d;
    int          hi;

    repeat (3) @(negedge clk);
    check("rst_read_data", read_data, 32'd0);
    check("rst_trigger", {30'd0, trigger}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_l = 1'b1;
    bus_read(CtrlA, d);
    check("rst_ctrl", d, 32'd0);
    bus_read(StatA, d);
    check("rst_status", d, 32'd0);
    read_ch(0, "rst_ch0");
    read_ch(1, "rst_ch1");

    // Basic two-channel scan, then a re-read shows valid cleared
    len = '{200, 300};
    dly = '{5, 5};
    run_scan("basic");
    read_ch(0, "reread_ch0");

    // Channel 1 never answers
    len[0] = int'($urandom_range(1, 600));
    dly[0] = int'($urandom_range(1, 40));
    len[1] = 0;
    run_scan("no_echo");

    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 2; k++) begin
        dly[k] = int'($urandom_range(1, 40));
        case ($urandom_range(0, 5))
          0:       len[k] = 0;
          1:       len[k] = 1100;
          default: len[k] = int'($urandom_range(1, 600));
        endcase
      end
      run_scan($sformatf("rand%0d", s));
    end

    // Register window edge cases
    bus_read(Base + 16'h0008, d);
    check("unmapped_ch2", d, 32'd0);
    bus_write(CtrlA, 32'd4);
    bus_read(CtrlA, d);
    check("ctrl_irq_en_only", d, 32'd4);
    bus_read(16'h0040, d);
    check("out_of_window_holds", d, 32'd4);
    bus_write(Base, 32'h1234_5678);
    read_ch(0, "ch0_write_ignored");
    bus_write(CtrlA, 32'd0);

    // Continuous scanning with interrupt, then abort mid-measure on channel 1
    len = '{100, 400};
    dly = '{5, 5};
    bus_write(StatA, 32'd1);
    bus_write(CtrlA, 32'd7);
    wait_irq("irq_scan1");
    bus_read(StatA, d);
    check("cont_status", d, 32'h0000_0001);
    bus_write(StatA, 32'd1);
    check("irq_w1c", {31'd0, irq}, 32'd0);
    wait_irq("irq_scan2");
    model_ch[0] = expect_ch(100);
    model_ch[1] = expect_ch(400);
    wait_trig(1, 1'b1, "abort_trig1_high");
    wait_trig(1, 1'b0, "abort_trig1_low");
    repeat (107) @(negedge clk);
    bus_write(CtrlA, 32'd0);
    check("abort_trigger", {30'd0, trigger}, 32'd0);
    check("abort_irq", {31'd0, irq}, 32'd0);
    hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (trigger !== 2'b00) hi++;
    end
    check("abort_stays_idle", 32'(hi), 32'd0);
    bus_read(StatA, d);
    check("abort_status", d, 32'h0000_0001);
    bus_read(CtrlA, d);
    check("abort_ctrl", d, 32'd0);
    read_ch(1, "abort_ch1");
    read_ch(0, "abort_ch0");
    wait_echo_idle();

    // Asynchronous reset during a trigger pulse
    read_ch(0, "pre_reset_ch0");
    bus_write(StatA, 32'd1);
    bus_write(CtrlA, 32'd1);
    wait_trig(0, 1'b1, "rst_trig0_high");
    repeat (2) @(negedge clk);
    check("pre_reset_trigger", {30'd0, trigger}, 32'd1);
    #2 reset_l = 1'b0;
    #1;
    check("async_rst_trigger", {30'd0, trigger}, 32'd0);
    check("async_rst_read_data", read_data, 32'd0);
    @(negedge clk);
    reset_l = 1'b1;
    model_ch = '{32'd0, 32'd0};
    bus_read(CtrlA, d);
    check("post_rst_ctrl", d, 32'd0);
    bus_read(StatA, d);
    check("post_rst_status", d, 32'd0);
    read_ch(0, "post_rst_ch0");
    read_ch(1, "post_rst_ch1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
